spi_bus_arbiter: RTL and testbench

- Shares one `spi_master` instance between two requesters, for example the button-driven `sending_data` source and a second data source.
- Arbitrates with a round-robin scheme and sequences each transfer through the master's start/done handshake.
- Captures the received word (MISO data) and returns it to the requester that owned the transfer.
- Sits between the data sources and `spi_master`, in the `clk` domain.

---
 rtl/spi_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one spi_master between two requesters.
// Optional WAIT timeout abort is compiled in when SPI_ARB_TIMEOUT_EN is defined.
module spi_bus_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              grant0,
    output logic              grant1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rx0,
    output logic [DATA_W-1:0] rx1,
    output logic              m_start,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic [DATA_W-1:0] m_rx,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic              r_last;     // winner of the latest grant; also the owner while busy
    logic              r_grant0;
    logic              r_grant1;
    logic              r_done0;
    logic              r_done1;
    logic              r_m_start;
    logic [DATA_W-1:0] r_m_data;
    logic [DATA_W-1:0] r_rx0;
    logic [DATA_W-1:0] r_rx1;

    logic w_req_any;
    logic w_pick1;
    logic w_timeout;

    assign w_req_any = req0 | req1;
    // Requester 1 wins when alone, or when both ask and requester 0 had the bus last.
    assign w_pick1   = req1 & (~req0 | ~r_last);

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Abort on the WAIT cycle that would bring the count to TIMEOUT; m_done wins a tie.
    assign w_timeout = (r_state == S_WAIT) && !m_done && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state != S_WAIT) begin
                r_cnt <= '0;
            end else if (!m_done) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT;
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: rx0/rx1 are plain registers, not a memory, so they take the async reset too.
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_grant0  <= 1'b0;
            r_grant1  <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_m_start <= 1'b0;
            r_m_data  <= '0;
            r_rx0     <= '0;
            r_rx1     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!m_busy && w_req_any) begin
                        r_state   <= S_START;
                        r_last    <= w_pick1;
                        r_grant0  <= ~w_pick1;
                        r_grant1  <= w_pick1;
                        r_m_start <= 1'b1;
                        r_m_data  <= w_pick1 ? data1 : data0;
                    end
                end
                S_START: begin
                    r_m_start <= 1'b0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (m_done) begin
                        r_state <= S_DONE;
                        if (r_last) begin
                            r_rx1   <= m_rx;
                            r_done1 <= 1'b1;
                        end else begin
                            r_rx0   <= m_rx;
                            r_done0 <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        // Aborted transfer: report completion but keep the old rx word.
                        r_state <= S_DONE;
                        r_done1 <= r_last;
                        r_done0 <= ~r_last;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_grant0 <= 1'b0;
                    r_grant1 <= 1'b0;
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant0  = r_grant0;
    assign grant1  = r_grant1;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign rx0     = r_rx0;
    assign rx1     = r_rx1;
    assign m_start = r_m_start;
    assign m_data  = r_m_data;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: a per-cycle vector table plus
// hand-written multi-cycle sequences (timeout sequence only with SPI_ARB_TIMEOUT_EN).
module tb_spi_bus_arbiter;

    localparam int DW         = 8;
    localparam int TB_TIMEOUT = 15;
    localparam int NV         = 19;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, m_busy, m_done;
    logic [DW-1:0] data0, data1, m_rx;
    logic          grant0, grant1, done0, done1, m_start, err;
    logic [DW-1:0] rx0, rx1, m_data;

    int n_cmp   = 0;
    int n_bad   = 0;
    int ovl     = 0;
    int err_hit = 0;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.DATA_W(DW), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .data0   (data0),
        .data1   (data1),
        .grant0  (grant0),
        .grant1  (grant1),
        .done0   (done0),
        .done1   (done1),
        .rx0     (rx0),
        .rx1     (rx1),
        .m_start (m_start),
        .m_data  (m_data),
        .m_busy  (m_busy),
        .m_done  (m_done),
        .m_rx    (m_rx),
        .err     (err)
    );

    typedef struct {
        logic          r0, r1, busy, mdone;
        logic [DW-1:0] mrx;
        logic          g0, g1, st, d0, d1;
        logic [DW-1:0] mdata, erx0, erx1;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic r0, input logic r1, input logic busy,
                                input logic mdone, input logic [DW-1:0] mrx,
                                input logic g0, input logic g1, input logic st,
                                input logic d0, input logic d1, input logic [DW-1:0] mdata,
                                input logic [DW-1:0] erx0, input logic [DW-1:0] erx1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.busy = busy; v.mdone = mdone; v.mrx = mrx;
        v.g0 = g0; v.g1 = g1; v.st = st; v.d0 = d0; v.d1 = d1;
        v.mdata = mdata; v.erx0 = erx0; v.erx1 = erx1;
        return v;
    endfunction

    function automatic logic [29:0] outs();
        return {grant0, grant1, m_start, done0, done1, err, m_data, rx0, rx1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Continuous monitors sampled away from the active edge.
    always @(negedge clk) begin
        if (grant0 && grant1) ovl++;
        if (err === 1'b1) err_hit++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Sequence bookkeeping
    int            t_start, t_done, t_err, n_start, n_d0, n_d1, n_err, g1_seen, done_at;
    int            low_run, ngap;
    logic          prev_g, seen_g;
    logic [DW-1:0] start_data;
    logic [DW-1:0] rx_at_done;
    logic [DW-1:0] alt_data [4];
    logic          alt_g1   [4];
    int            gaps     [4];

    initial begin
        //                r0 r1 bz md mrx    g0 g1 st d0 d1 mdata  rx0    rx1
        vecs[0]  = mk(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00); // stray done in IDLE
        vecs[1]  = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00); // busy blocks grant
        vecs[2]  = mk(1, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h5A, 8'h00, 8'h00);
        vecs[3]  = mk(0, 0, 0, 1, 8'h11, 1, 0, 0, 0, 0, 8'h5A, 8'h00, 8'h00); // stray done in START
        vecs[4]  = mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h5A, 8'h00, 8'h00);
        vecs[5]  = mk(0, 0, 0, 1, 8'h77, 1, 0, 0, 1, 0, 8'h5A, 8'h77, 8'h00);
        vecs[6]  = mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 8'h77, 8'h00);
        vecs[7]  = mk(0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'hC3, 8'h77, 8'h00);
        vecs[8]  = mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'hC3, 8'h77, 8'h00); // req dropped
        vecs[9]  = mk(1, 1, 0, 1, 8'h99, 0, 1, 0, 0, 1, 8'hC3, 8'h77, 8'h99);
        vecs[10] = mk(1, 1, 0, 1, 8'hEE, 0, 0, 0, 0, 0, 8'hC3, 8'h77, 8'h99); // stray done in DONE
        vecs[11] = mk(1, 1, 0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h5A, 8'h77, 8'h99); // last=1 -> req0
        vecs[12] = mk(1, 1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h5A, 8'h77, 8'h99);
        vecs[13] = mk(1, 1, 0, 1, 8'h12, 1, 0, 0, 1, 0, 8'h5A, 8'h12, 8'h99);
        vecs[14] = mk(1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 8'h12, 8'h99);
        vecs[15] = mk(1, 1, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'hC3, 8'h12, 8'h99); // last=0 -> req1
        vecs[16] = mk(1, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'hC3, 8'h12, 8'h99);
        vecs[17] = mk(0, 0, 0, 1, 8'h34, 0, 1, 0, 0, 1, 8'hC3, 8'h12, 8'h34);
        vecs[18] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hC3, 8'h12, 8'h34);

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rx = '0;
        data0 = 8'h5A; data1 = 8'hC3;
        @(negedge clk);
        check("reset_state", outs(), '0);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1;
            m_busy = vecs[i].busy; m_done = vecs[i].mdone; m_rx = vecs[i].mrx;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].g0, vecs[i].g1, vecs[i].st, vecs[i].d0, vecs[i].d1, 1'b0,
                   vecs[i].mdata, vecs[i].erx0, vecs[i].erx1});
        end
        req0 = 1'b0; req1 = 1'b0; m_done = 1'b0;

        // ---------------- single request, done 10 cycles after start ----------------
        data0 = 8'hA5; req0 = 1'b1;
        t_start = -1; t_done = -1; n_start = 0; n_d0 = 0; g1_seen = 0;
        start_data = '0; rx_at_done = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_start) begin n_start++; t_start = c; start_data = m_data; end
            if (done0) begin n_d0++; t_done = c; rx_at_done = rx0; end
            if (grant1) g1_seen++;
            if (t_start >= 0) req0 = 1'b0;
            m_done = (t_start >= 0) && (c == t_start + 10);
            m_rx   = 8'h3C;
        end
        m_done = 1'b0;
        check("single_start_cnt", n_start, 1);
        check("single_m_data", start_data, 8'hA5);
        check("single_done_cnt", n_d0, 1);
        check("single_done_lat", t_done - t_start, 11);
        check("single_rx0", rx_at_done, 8'h3C);
        check("single_grant1", g1_seen, 0);
        check("single_idle", {grant0, grant1, rx0}, {2'b00, 8'h3C});

        // ---------------- reset in the middle of WAIT ----------------
        data0 = 8'h77; req0 = 1'b1;
        @(negedge clk);
        check("rst_pre_grant", {grant0, m_start}, 2'b11);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async_clear", outs(), '0);
        @(negedge clk);
        rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 8'h61; data1 = 8'h62;
        @(negedge clk);
        check("rst_first_winner", {grant0, grant1, m_start, m_data}, {3'b101, 8'h61});
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        m_done = 1'b1; m_rx = 8'h5C;
        @(negedge clk);
        m_done = 1'b0;
        check("rst_after_done", {grant0, done0, rx0}, {2'b11, 8'h5C});
        @(negedge clk);

        // ---------------- busy master holds off the grant ----------------
        m_busy = 1'b1; req1 = 1'b1; data1 = 8'h9D;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("busy_nogrant%0d", c), {grant0, grant1, m_start}, 3'b000);
        end
        m_busy = 1'b0;
        @(negedge clk);
        check("busy_release_grant", {grant0, grant1, m_start, m_data}, {3'b011, 8'h9D});
        req1 = 1'b0;
        @(negedge clk);
        m_done = 1'b1; m_rx = 8'hB4;
        @(negedge clk);
        m_done = 1'b0;
        check("busy_done1", {done1, rx1}, {1'b1, 8'hB4});
        @(negedge clk);

        // ---------------- simultaneous requests alternate ----------------
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        data0 = 8'h11; data1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
        n_start = 0; n_d0 = 0; n_d1 = 0; done_at = -1;
        low_run = 0; ngap = 0; prev_g = 1'b0; seen_g = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m_start) begin
                if (n_start < 4) begin alt_data[n_start] = m_data; alt_g1[n_start] = grant1; end
                n_start++;
                done_at = c + 2;
                m_rx = ~m_data;
            end
            if (done0) n_d0++;
            if (done1) n_d1++;
            if ((grant0 | grant1) && !prev_g && seen_g && ngap < 4) begin
                gaps[ngap] = low_run; ngap++;
            end
            if (grant0 | grant1) begin seen_g = 1'b1; low_run = 0; end
            else low_run++;
            prev_g = grant0 | grant1;
            if (c == 16) begin req0 = 1'b0; req1 = 1'b0; end
            m_done = (c == done_at);
        end
        m_done = 1'b0;
        check("alt_start_cnt", n_start, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("alt_data%0d", i), alt_data[i], (i % 2 == 0) ? 8'h11 : 8'h22);
            check($sformatf("alt_owner%0d", i), alt_g1[i], (i % 2 == 1));
        end
        check("alt_gap_cnt", ngap, 3);
        for (int i = 0; i < 3; i++) check($sformatf("alt_gap%0d", i), gaps[i], 1);
        check("alt_done_cnt", {n_d0[7:0], n_d1[7:0]}, {8'd2, 8'd2});
        check("alt_rx", {rx0, rx1}, {8'hEE, 8'hDD});

`ifdef SPI_ARB_TIMEOUT_EN
        // ---------------- timeout with m_done withheld ----------------
        data0 = 8'h42; req0 = 1'b1; m_done = 1'b0;
        t_start = -1; t_done = -1; t_err = -1; n_err = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_start) t_start = c;
            if (done0) t_done = c;
            if (err) begin n_err++; t_err = c; end
            if (t_start >= 0) req0 = 1'b0;
        end
        // WAIT begins one cycle after m_start; abort lands TB_TIMEOUT cycles later.
        check("to_err_lat", t_err - t_start, TB_TIMEOUT + 1);
        check("to_done_lat", t_done - t_start, TB_TIMEOUT + 1);
        check("to_err_cnt", n_err, 1);
        check("to_rx0_kept", rx0, 8'hEE);
        check("to_idle", {grant0, grant1, done0, err}, 4'b0000);
        check("err_pulses", err_hit, 1);
`else
        check("err_never", err_hit, 0);
`endif

        check("grant_overlap", ovl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
